// File: rtl/t09_score_tracker.sv
// Score tracker: BCD running score, session high score and game state.
// Consumes single-cycle collision pulses and emits a score sound pulse.
module t09_score_tracker #(
    parameter int DIGITS    = 3,
    parameter int WIN_SCORE = 50
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                start,
    input  logic                goodColl,
    input  logic                badColl,
    output logic [4*DIGITS-1:0] score,
    output logic [4*DIGITS-1:0] high_score,
    output logic [1:0]          state,
    output logic                score_pulse
);

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        PLAY = 2'b01,
        LOSE = 2'b10,
        WIN  = 2'b11
    } state_t;

    function automatic logic [4*DIGITS-1:0] to_bcd(input int v);
        int r;
        r = v;
        to_bcd = '0;
        for (int i = 0; i < DIGITS; i++) begin
            to_bcd[4*i +: 4] = 4'(r % 10);
            r = r / 10;
        end
    endfunction

    localparam logic [4*DIGITS-1:0] WIN_BCD = to_bcd(WIN_SCORE);

    state_t              state_q, state_d;
    logic [4*DIGITS-1:0] score_q, score_d;
    logic [4*DIGITS-1:0] high_q, high_d;
    logic                pulse_q, pulse_d;

    logic [4*DIGITS-1:0] inc;
    logic                carry;
    logic                all9;

    // BCD increment with ripple carry; all9 flags the saturation point
    always_comb begin
        inc   = score_q;
        carry = 1'b1;
        all9  = 1'b1;
        for (int i = 0; i < DIGITS; i++) begin
            if (score_q[4*i +: 4] != 4'd9) all9 = 1'b0;
            if (carry) begin
                if (score_q[4*i +: 4] == 4'd9) begin
                    inc[4*i +: 4] = 4'd0;
                end else begin
                    inc[4*i +: 4] = score_q[4*i +: 4] + 4'd1;
                    carry         = 1'b0;
                end
            end
        end
    end

    // Next-state, score and high-score update
    always_comb begin
        state_d = state_q;
        score_d = score_q;
        high_d  = high_q;
        pulse_d = 1'b0;
        unique case (state_q)
            IDLE, LOSE, WIN: begin
                if (start) begin
                    state_d = PLAY;
                    score_d = '0;
                end
            end
            PLAY: begin
                if (badColl) begin
                    state_d = LOSE;
                    if (score_q > high_q) high_d = score_q;
                end else if (goodColl && !all9) begin
                    score_d = inc;
                    if (inc == WIN_BCD) begin
                        // Winning increment: the pulse is suppressed so it
                        // never shows up while the state reads WIN.
                        state_d = WIN;
                        if (inc > high_q) high_d = inc;
                    end else begin
                        pulse_d = 1'b1;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // State and output registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            score_q <= '0;
            high_q  <= '0;
            pulse_q <= 1'b0;
        end else begin
            state_q <= state_d;
            score_q <= score_d;
            high_q  <= high_d;
            pulse_q <= pulse_d;
        end
    end

    assign score       = score_q;
    assign high_score  = high_q;
    assign state       = state_q;
    assign score_pulse = pulse_q;

endmodule
